// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for one Montgomery multiplier.
// Computes X^E mod M and converts the accumulator back to plain form.
module montgomery_exp_ctrl #(
   parameter int unsigned WIDTH     = 1024,
   parameter int unsigned EXP_WIDTH = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_r,
   input  logic [EXP_WIDTH-1:0] in_e,
   input  logic [WIDTH-1:0]     in_m,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   output logic [WIDTH-1:0]     mul_m,
   input  logic [WIDTH:0]       mul_result,
   input  logic                 mul_done
);

   localparam int unsigned CW = $clog2(EXP_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_FIX, S_NEXT, S_DONE
   } state_t;

   typedef enum logic [1:0] {OP_SQR, OP_MUL, OP_CONV} op_t;

   state_t               state, state_d;
   op_t                  op, op_d;
   logic [WIDTH-1:0]     x_q, x_d, m_q, m_d, a_q, a_d;
   logic [EXP_WIDTH-1:0] e_q, e_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic                 busy_d, done_d, mul_start_d;
   logic [WIDTH-1:0]     result_d, mul_a_d, mul_b_d, mul_m_d;

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op        <= OP_SQR;
         x_q       <= '0;
         m_q       <= '0;
         a_q       <= '0;
         e_q       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_m     <= '0;
      end else begin
         state     <= state_d;
         op        <= op_d;
         x_q       <= x_d;
         m_q       <= m_d;
         a_q       <= a_d;
         e_q       <= e_d;
         cnt       <= cnt_d;
         busy      <= busy_d;
         done      <= done_d;
         result    <= result_d;
         mul_start <= mul_start_d;
         mul_a     <= mul_a_d;
         mul_b     <= mul_b_d;
         mul_m     <= mul_m_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      op_d        = op;
      x_d         = x_q;
      m_d         = m_q;
      a_d         = a_q;
      e_d         = e_q;
      cnt_d       = cnt;
      busy_d      = busy;
      done_d      = 1'b0;
      result_d    = result;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a;
      mul_b_d     = mul_b;
      mul_m_d     = mul_m;

      case (state)
         S_IDLE: begin
            if (start) begin
               x_d     = in_x;
               m_d     = in_m;
               e_d     = in_e;
               a_d     = in_r;
               cnt_d   = CW'(EXP_WIDTH);
               busy_d  = 1'b1;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (e_q[EXP_WIDTH-1]) begin
               // Leading one: A = X replaces the first square/multiply
               a_d     = x_q;
               e_d     = e_q << 1;
               cnt_d   = cnt - CW'(1);
               state_d = S_NEXT;
            end else if (cnt == CW'(1)) begin
               op_d    = OP_CONV;
               state_d = S_ISSUE;
            end else begin
               e_d   = e_q << 1;
               cnt_d = cnt - CW'(1);
            end
         end
         S_NEXT: begin
            op_d    = (cnt != '0) ? OP_SQR : OP_CONV;
            state_d = S_ISSUE;
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (mul_done) begin
               a_d = (mul_result >= {1'b0, m_q}) ? WIDTH'(mul_result - {1'b0, m_q})
                                                 : WIDTH'(mul_result);
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            case (op)
               OP_SQR: begin
                  e_d   = e_q << 1;
                  cnt_d = cnt - CW'(1);
                  if (e_q[EXP_WIDTH-1]) begin
                     op_d    = OP_MUL;
                     state_d = S_ISSUE;
                  end else begin
                     state_d = S_NEXT;
                  end
               end
               OP_MUL: state_d = S_NEXT;
               default: begin
                  result_d = a_q;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = S_DONE;
               end
            endcase
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Operands are loaded on entry to ISSUE so mul_start and data align
      if (state_d == S_ISSUE) begin
         mul_start_d = 1'b1;
         mul_a_d     = a_d;
         mul_m_d     = m_q;
         case (op_d)
            OP_MUL:  mul_b_d = x_q;
            OP_CONV: mul_b_d = WIDTH'(1);
            default: mul_b_d = a_d;
         endcase
      end
   end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: bit-serial Montgomery multiplier model,
// plain modular-exponentiation golden model and a per-cycle checker.
module tb_montgomery_exp_ctrl;
   localparam int unsigned W  = 1024;
   localparam int unsigned EW = 1024;

   logic          clk, reset, start;
   logic [W-1:0]  in_x, in_r, in_m;
   logic [EW-1:0] in_e;
   logic          busy, done, mul_start;
   logic [W-1:0]  result, mul_a, mul_b, mul_m;
   logic [W:0]    mul_result = '0;
   logic          mul_done = 1'b0;

   montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_m(in_m),
      .busy(busy), .done(done), .result(result),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
      .mul_result(mul_result), .mul_done(mul_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0, nfail = 0;
   int done_cnt = 0, accepted_cnt = 0, starts_total = 0;
   int run_s0 = 0, d0 = 0, exp_nstarts = 0;
   int lat_lo = 1, lat_hi = 1, spur_req = 0, spur_done = 0;
   bit plus_m = 1'b0, outstanding = 1'b0;
   logic [W-1:0] exp_result = '0, cur_m = '0, hold_val = '0, cap_a = '0, cap_b = '0;

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // a*b*2^-W mod m (result < 2m), bit-serial reduction
   function automatic logic [W:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] m);
      logic [W+1:0] t;
      t = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, m};
         t = t >> 1;
      end
      return (W+1)'(t);
   endfunction

   function automatic logic [W:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
      logic [W:0] r;
      r = mont(a, b, m);
      if (r >= {1'b0, m}) r = r - {1'b0, m};
      if (plus_m) r = r + {1'b0, m};
      return r;
   endfunction

   function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
      logic [2*W-1:0] one_r;
      one_r = '0;
      one_r[W] = 1'b1;
      return W'(one_r % {W'(0), m});
   endfunction

   function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] m);
      return W'({x, W'(0)} % {W'(0), m});
   endfunction

   function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [EW-1:0] e,
                                           input logic [W-1:0] m);
      logic [2*W-1:0] r, xx, mm;
      xx = {W'(0), x};
      mm = {W'(0), m};
      r  = (2*W)'(1) % mm;
      for (int i = int'(EW) - 1; i >= 0; i--) begin
         r = (r * r) % mm;
         if (e[i]) r = (r * xx) % mm;
      end
      return W'(r);
   endfunction

   function automatic int exp_count(input logic [EW-1:0] e);
      int k;
      k = -1;
      for (int i = 0; i < int'(EW); i++) if (e[i]) k = i;
      if (k < 0) return 1;
      return k + $countones(e);
   endfunction

   // Multiplier model: picks up operands while mul_start is high, answers after latency
   bit         job = 1'b0;
   int         remaining = 0;
   logic [W:0] job_res = '0;
   always @(posedge clk) begin
      #1;
      mul_done = 1'b0;
      if (reset) begin
         job = 1'b0;
         spur_done = spur_req;
      end else begin
         if (job) begin
            if (remaining <= 1) begin
               mul_done = 1'b1;
               mul_result = job_res;
               job = 1'b0;
            end else begin
               remaining--;
            end
         end else if (spur_done != spur_req) begin
            mul_done = 1'b1;
            mul_result = {1'b0, rand_w()};
            spur_done++;
         end
         if (mul_start) begin
            job = 1'b1;
            remaining = int'($urandom_range(lat_hi, lat_lo));
            job_res = mul_model(mul_a, mul_b, mul_m);
         end
      end
   end

   // Per-cycle checker
   always @(negedge clk) begin
      if (reset) begin
         outstanding = 1'b0;
         hold_val = '0;
      end else begin
         if (mul_start) begin
            chk("mul_start_overlap", (W+1)'(outstanding), (W+1)'(0));
            chk("mul_start_when_idle", (W+1)'(accepted_cnt != done_cnt), (W+1)'(1));
            chk("mul_m", {1'b0, mul_m}, {1'b0, cur_m});
            outstanding = 1'b1;
            cap_a = mul_a;
            cap_b = mul_b;
            starts_total++;
         end else if (outstanding) begin
            chk("operands_held", (W+1)'(mul_a == cap_a && mul_b == cap_b && mul_m == cur_m),
                (W+1)'(1));
         end
         if (mul_done) outstanding = 1'b0;
         if (done) begin
            done_cnt++;
            hold_val = exp_result;
            chk("result", {1'b0, result}, {1'b0, exp_result});
            chk("mul_count", (W+1)'(starts_total - run_s0), (W+1)'(exp_nstarts));
         end
         chk("busy", (W+1)'(busy), (W+1)'(accepted_cnt != done_cnt));
         if (!done && accepted_cnt == done_cnt)
            chk("result_hold", {1'b0, result}, {1'b0, hold_val});
      end
   end

   task automatic start_op(input logic [W-1:0] xm, input logic [EW-1:0] e,
                           input logic [W-1:0] m, input logic [W-1:0] expv, input int nst,
                           input int lo, input int hi, input bit pm);
      @(posedge clk); #1;
      lat_lo = lo; lat_hi = hi; plus_m = pm;
      cur_m = m; exp_result = expv; exp_nstarts = nst;
      in_x = xm; in_e = e; in_m = m; in_r = rmod(m);
      run_s0 = starts_total;
      d0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      accepted_cnt++;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 50000) begin
         @(negedge clk); #1;
         n++;
      end
      chk({name, "_timeout"}, (W+1)'(done_cnt != d0), (W+1)'(1));
      repeat (3) @(negedge clk);
      #1;
      chk({name, "_done_pulses"}, (W+1)'(done_cnt - d0), (W+1)'(1));
   endtask

   task automatic run(input string name, input logic [W-1:0] xm, input logic [EW-1:0] e,
                      input logic [W-1:0] m, input logic [W-1:0] expv, input int nst,
                      input int lo, input int hi, input bit pm);
      start_op(xm, e, m, expv, nst, lo, hi, pm);
      wait_done(name);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"},      (W+1)'(busy),      '0);
      chk({name, "_done"},      (W+1)'(done),      '0);
      chk({name, "_mul_start"}, (W+1)'(mul_start), '0);
      chk({name, "_result"},    {1'b0, result},    '0);
      chk({name, "_mul_a"},     {1'b0, mul_a},     '0);
      chk({name, "_mul_b"},     {1'b0, mul_b},     '0);
      chk({name, "_mul_m"},     {1'b0, mul_m},     '0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]  m, x;
      logic [EW-1:0] e;
      int n;
      reset = 1'b1; start = 1'b0;
      in_x = '0; in_r = '0; in_e = '0; in_m = '0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      @(negedge clk); #1;
      chk_all_zero("reset");

      // Model pins: 2^1024 mod 13 = 3, so 3R mod 13 = 9 and 7R mod 13 = 8
      chk("model_rmod13", {1'b0, rmod(W'(13))}, (W+1)'(3));
      chk("model_tomont3", {1'b0, to_mont(W'(3), W'(13))}, (W+1)'(9));
      chk("model_mont", mont(W'(9), W'(1), W'(13)) % (W+1)'(13), (W+1)'(3));
      chk("model_modexp", {1'b0, modexp(W'(3), EW'(5), W'(13))}, (W+1)'(9));
      chk("model_count5", (W+1)'(exp_count(EW'(5))), (W+1)'(4));

      run("e5",     W'(9), EW'(5),  W'(13), W'(9), 4, 1, 40, 1'b0);
      run("e0",     W'(9), EW'(0),  W'(13), W'(1), 1, 1, 40, 1'b0);
      run("e1",     W'(8), EW'(1),  W'(13), W'(7), 1, 1, 40, 1'b0);
      run("e13",    W'(9), EW'(13), W'(13), W'(3), 6, 1, 40, 1'b0);
      run("e5_pm",  W'(9), EW'(5),  W'(13), W'(9), 4, 1, 40, 1'b1);
      run("x0_pm",  W'(0), EW'(5),  W'(13), W'(0), 4, 1, 10, 1'b1);

      // start during WAIT, then a spurious mul_done while idle
      start_op(W'(9), EW'(5), W'(13), W'(9), 4, 5, 40, 1'b0);
      n = 0;
      while (!outstanding && n < 50000) begin
         @(negedge clk); #1;
         n++;
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done("inj_start");
      spur_req++;
      repeat (6) @(negedge clk);
      #1;
      chk("spur_result", {1'b0, result}, (W+1)'(9));
      chk("spur_busy", (W+1)'(busy), '0);

      // reset during the second WAIT
      start_op(W'(9), EW'(5), W'(13), W'(9), 4, 10, 10, 1'b0);
      n = 0;
      while ((starts_total - run_s0) < 2 && n < 50000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("rst_second_mul", (W+1)'(starts_total - run_s0), (W+1)'(2));
      @(posedge clk); #3 reset = 1'b1;
      #1;
      chk_all_zero("midrst");
      repeat (2) @(posedge clk);
      #3;
      accepted_cnt = done_cnt;
      reset = 1'b0;
      run("after_rst", W'(9), EW'(5), W'(13), W'(9), 4, 1, 40, 1'b0);

      // full-width vectors against the plain golden model
      m = rand_w(); m[W-1] = 1'b1; m[0] = 1'b1;
      x = rand_w(); x[W-1] = 1'b0;
      e = EW'(rand_w()); e[EW-1] = 1'b1;
      run("full", to_mont(x, m), e, m, modexp(x, e, m), exp_count(e), 1, 4, 1'b0);

      m = rand_w(); m[W-1] = 1'b1; m[0] = 1'b1;
      x = rand_w(); x[W-1] = 1'b0;
      e = '0; e[63:0] = {$urandom, $urandom}; e[63] = 1'b1;
      run("full_pm", to_mont(x, m), e, m, modexp(x, e, m), exp_count(e), 1, 40, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
